// File: rtl/operand_pkg.sv
// Shared encodings for the operand-B stage: immediate-extension modes and rt forwarding selects.
package operand_pkg;

  localparam logic [2:0] EXT_ZERO   = 3'b000;
  localparam logic [2:0] EXT_SIGN   = 3'b001;
  localparam logic [2:0] EXT_UPPER  = 3'b010;
  localparam logic [2:0] EXT_BRANCH = 3'b011;
  localparam logic [2:0] EXT_SHAMT  = 3'b100;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/operand_b_stage_imm_ext.sv
// Combinational immediate extender: zero, sign, upper, branch-offset and shift-amount modes.
module imm_ext
  import operand_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        extop,
  output logic [DATA_W-1:0] ext
);

  logic [DATA_W-1:0] zext;
  logic [DATA_W-1:0] sext;

  always_comb begin
    zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    ext  = '0;
    case (extop)
      EXT_ZERO:   ext = zext;
      EXT_SIGN:   ext = sext;
      // Shifting within DATA_W gives the truncation of the upper/branch forms for free.
      EXT_UPPER:  ext = zext << IMM_W;
      EXT_BRANCH: ext = sext << 2;
      EXT_SHAMT:  ext = {{(DATA_W-SHAMT_W){1'b0}}, imm[6 +: SHAMT_W]};
      default:    ext = '0;
    endcase
  end

endmodule

// File: rtl/operand_b_stage.sv
// ID/EX operand-B stage: rt forwarding, immediate extension and ALU-B select behind a
// valid/ready register with a one-entry skid buffer.
module operand_b_stage
  import operand_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IMM_W   = 16,
  parameter int unsigned SHAMT_W = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm,
  input  logic [2:0]        extop,
  input  logic              b_sel,
  input  logic [1:0]        fwd_sel,
  input  logic [DATA_W-1:0] rf_b,
  input  logic [DATA_W-1:0] ex_fwd,
  input  logic [DATA_W-1:0] mem_fwd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_b,
  output logic [DATA_W-1:0] store_b
);

  logic [DATA_W-1:0] ext;
  logic [DATA_W-1:0] fwd_b;
  logic [DATA_W-1:0] alu_in;

  logic [DATA_W-1:0] main_alu_q, main_alu_d;
  logic [DATA_W-1:0] main_st_q,  main_st_d;
  logic              main_valid_q, main_valid_d;
  logic [DATA_W-1:0] skid_alu_q, skid_alu_d;
  logic [DATA_W-1:0] skid_st_q,  skid_st_d;
  logic              skid_valid_q, skid_valid_d;

  logic accept;
  logic main_free;

  imm_ext #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .SHAMT_W(SHAMT_W)
  ) u_imm_ext (
    .imm  (imm),
    .extop(extop),
    .ext  (ext)
  );

  always_comb begin
    case (fwd_sel)
      FWD_EX:  fwd_b = ex_fwd;
      FWD_MEM: fwd_b = mem_fwd;
      default: fwd_b = rf_b;
    endcase
    alu_in = b_sel ? ext : fwd_b;
  end

  assign in_ready  = ~skid_valid_q;
  assign accept    = in_valid & in_ready;
  assign main_free = ~main_valid_q | out_ready;

  always_comb begin
    main_alu_d   = main_alu_q;
    main_st_d    = main_st_q;
    main_valid_d = main_valid_q;
    skid_alu_d   = skid_alu_q;
    skid_st_d    = skid_st_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      // A full skid implies in_ready=0, so refilling main from skid never races an accept.
      if (skid_valid_q) begin
        main_alu_d   = skid_alu_q;
        main_st_d    = skid_st_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_alu_d   = alu_in;
        main_st_d    = fwd_b;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_alu_d   = alu_in;
      skid_st_d    = fwd_b;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_alu_q   <= '0;
      main_st_q    <= '0;
      main_valid_q <= 1'b0;
      skid_alu_q   <= '0;
      skid_st_q    <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_alu_q   <= main_alu_d;
      main_st_q    <= main_st_d;
      main_valid_q <= main_valid_d;
      skid_alu_q   <= skid_alu_d;
      skid_st_q    <= skid_st_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid = main_valid_q;
  assign alu_b     = main_alu_q;
  assign store_b   = main_st_q;

endmodule
